// File: rtl/video_stream_logger_if.sv
// video_stream_logger_if
//   Valid/ready word stream from the logger FIFO to a capture/DMA or bench sink.
//   Parameter:
//     DATA_W     word width, {TAG[1:0], PAYLOAD}; set it to PIX_W+2 of the logger.
//   Signals:
//     OUT_VALID  source -> sink  FIFO not empty, OUT_DATA holds the head word
//     OUT_READY  sink -> source  sink accepts the head word this cycle
//     OUT_DATA   source -> sink  head word
//   Modports:
//     master     the logger (drives OUT_VALID/OUT_DATA)
//     slave      the sink (drives OUT_READY)
interface video_stream_logger_if #(
  parameter int DATA_W = 23
) ();

  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_DATA;

  modport master (
    output OUT_VALID,
    output OUT_DATA,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_DATA,
    output OUT_READY
  );

endinterface

// File: rtl/video_stream_logger.sv
// video_stream_logger
//   Tracks raster position from a pixel-enable strobe and captures a programmable
//   number of whole frames of blank-masked pixel words, with line-end and frame-end
//   marker words, into a first-word-fall-through FIFO drained over a valid/ready
//   stream. Also latches NUM_LED LED/marquee channels on their strobe falling edges
//   and snapshots them together with the cabinet flags on every frame end.
//
//   Ports:
//     CLK_6MB     in   sole clock, rising edge
//     nRESET      in   asynchronous active-low reset
//     PIX_EN      in   one pixel slot per high cycle
//     PIX_DATA    in   pixel value
//     nBNKB       in   0 = blanked, captured pixel payload forced to 0
//     CAP_START   in   one-cycle arm pulse (ignored unless idle)
//     CAP_FRAMES  in   frames to capture, 0 = continuous
//     LED_DATA    in   shared LED data bus
//     LED_LATCH   in   per-channel latch strobes, latch on falling edge
//     CAB_FLAGS   in   {COUNTER1, COUNTER2, LOCKOUT1, LOCKOUT2}
//     out_if      master side of the word stream (OUT_VALID/OUT_READY/OUT_DATA)
//     HCOUNT      out  current pixel slot
//     LINE        out  current line
//     FRAME       out  frame counter (wraps at 16 bits)
//     CAB_SNAP    out  {CAB_FLAGS, LED[NUM_LED-1] .. LED[0]} at the last frame end
//     BUSY        out  capture state machine not idle
//     OVERFLOW    out  sticky, at least one word dropped since arming
//     DROP_CNT    out  dropped-word count, saturating
//
//   Output word format: {TAG[1:0], PAYLOAD}
//     00 pixel (blank-masked), 01 line end (payload 0), 10 frame end (payload FRAME).
module video_stream_logger #(
  parameter int PIX_W      = 21,
  parameter int H_TOTAL    = 384,
  parameter int V_TOTAL    = 264,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_LED    = 2,
  parameter int LED_W      = 8,
  localparam int HC_W      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int LN_W      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
  localparam int SNAP_W    = NUM_LED * LED_W + 4
) (
  input  logic                 CLK_6MB,
  input  logic                 nRESET,
  input  logic                 PIX_EN,
  input  logic [PIX_W-1:0]     PIX_DATA,
  input  logic                 nBNKB,
  input  logic                 CAP_START,
  input  logic [7:0]           CAP_FRAMES,
  input  logic [LED_W-1:0]     LED_DATA,
  input  logic [NUM_LED-1:0]   LED_LATCH,
  input  logic [3:0]           CAB_FLAGS,
  video_stream_logger_if.master out_if,
  output logic [HC_W-1:0]      HCOUNT,
  output logic [LN_W-1:0]      LINE,
  output logic [15:0]          FRAME,
  output logic [SNAP_W-1:0]    CAB_SNAP,
  output logic                 BUSY,
  output logic                 OVERFLOW,
  output logic [15:0]          DROP_CNT
);

  localparam int WORD_W = PIX_W + 2;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
  localparam logic [LN_W-1:0] V_LAST    = LN_W'(V_TOTAL - 1);
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DRAIN
  } state_t;

  // Raster counters
  logic [HC_W-1:0] hcount_q;
  logic [LN_W-1:0] line_q;
  logic [15:0]     frame_q;

  // Slot classification
  logic              h_last;
  logic              l_last;
  logic              frame_end;
  logic [PIX_W-1:0]  pix_masked;
  logic [PIX_W-1:0]  frame_payload;
  logic [WORD_W-1:0] slot_word;

  // Capture control
  state_t     state_q;
  state_t     state_d;
  logic [7:0] remain_q;
  logic [7:0] remain_d;
  logic       push_req;
  logic       arm;

  // FIFO
  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // LED channels and snapshot
  logic [NUM_LED-1:0]            led_prev_q;
  logic [NUM_LED-1:0][LED_W-1:0] led_q;
  logic [SNAP_W-1:0]             cab_snap_q;

  // Statistics
  logic        overflow_q;
  logic [15:0] drop_cnt_q;

  assign h_last    = (hcount_q == H_LAST);
  assign l_last    = (line_q == V_LAST);
  assign frame_end = h_last && l_last;

  // Raster position runs on PIX_EN alone, whatever the capture state.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      hcount_q <= '0;
      line_q   <= '0;
      frame_q  <= '0;
    end else if (PIX_EN) begin
      if (h_last) begin
        hcount_q <= '0;
        if (l_last) begin
          line_q  <= '0;
          frame_q <= frame_q + 16'd1;
        end else begin
          line_q <= line_q + 1'b1;
        end
      end else begin
        hcount_q <= hcount_q + 1'b1;
      end
    end
  end

  // The last slot of every line carries a marker instead of a pixel; on the last
  // line that marker is a frame end stamped with the (pre-increment) frame number.
  assign pix_masked    = nBNKB ? PIX_DATA : '0;
  assign frame_payload = PIX_W'(frame_q);

  always_comb begin
    slot_word = '0;
    if (!h_last) begin
      slot_word = {2'b00, pix_masked};
    end else if (!l_last) begin
      slot_word = {2'b01, {PIX_W{1'b0}}};
    end else begin
      slot_word = {2'b10, frame_payload};
    end
  end

  // Capture state register and frame budget.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  // Capture sequencing. The budget counts frame-end attempts, so a frame end that
  // is dropped by a full FIFO still finishes its frame. A zero budget never
  // decrements, which is what makes CAP_FRAMES=0 continuous.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    push_req = 1'b0;
    arm      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CAP_START) begin
          state_d  = WAIT_SOF;
          remain_d = CAP_FRAMES;
          arm      = 1'b1;
        end
      end
      WAIT_SOF: begin
        if (PIX_EN && (hcount_q == '0) && (line_q == '0)) begin
          push_req = 1'b1;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (PIX_EN) begin
          push_req = 1'b1;
          if (frame_end && (remain_q != 8'd0)) begin
            remain_d = remain_q - 8'd1;
            if (remain_q == 8'd1) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a
  // push when the sink is reading; only push-while-full-without-pop drops.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign pop        = !fifo_empty && out_if.OUT_READY;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  // FIFO storage and pointers. Storage is cleared on reset so the head word
  // reads as zero while the FIFO is empty after reset.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr_q] <= slot_word;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Drop statistics are cleared when a new capture is armed, not when it ends,
  // so they stay readable after the capture completes.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (arm) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // LED channels latch on the falling edge of their strobe. The previous-strobe
  // register resets low, so a strobe held low through reset is not an edge.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      led_prev_q <= '0;
      led_q      <= '0;
    end else begin
      led_prev_q <= LED_LATCH;
      for (int i = 0; i < NUM_LED; i++) begin
        if (led_prev_q[i] && !LED_LATCH[i]) begin
          led_q[i] <= LED_DATA;
        end
      end
    end
  end

  // Cabinet snapshot taken on every frame-end slot regardless of capture state.
  always_ff @(posedge CLK_6MB or negedge nRESET) begin
    if (!nRESET) begin
      cab_snap_q <= '0;
    end else if (PIX_EN && frame_end) begin
      cab_snap_q <= {CAB_FLAGS, led_q};
    end
  end

  assign out_if.OUT_VALID = !fifo_empty;
  assign out_if.OUT_DATA  = fifo_mem[rd_ptr_q];

  assign HCOUNT   = hcount_q;
  assign LINE     = line_q;
  assign FRAME    = frame_q;
  assign CAB_SNAP = cab_snap_q;
  assign BUSY     = (state_q != IDLE);
  assign OVERFLOW = overflow_q;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_video_stream_logger.sv
// tb_video_stream_logger
//   Self-checking bench for video_stream_logger with a tiny raster (4 slots x 2
//   lines) and a 4-entry FIFO. The stimulus task keeps a reference raster and
//   capture model and queues every word the sink should receive; a sink monitor
//   pops that queue on each accepted handshake and compares.
module tb_video_stream_logger;

  localparam int PIX_W      = 21;
  localparam int H_TOTAL    = 4;
  localparam int V_TOTAL    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_LED    = 2;
  localparam int LED_W      = 8;
  localparam int WORD_W     = PIX_W + 2;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_CAP   = 2;
  localparam int M_DRAIN = 3;

  logic                  CLK_6MB;
  logic                  nRESET;
  logic                  PIX_EN;
  logic [PIX_W-1:0]      PIX_DATA;
  logic                  nBNKB;
  logic                  CAP_START;
  logic [7:0]            CAP_FRAMES;
  logic [LED_W-1:0]      LED_DATA;
  logic [NUM_LED-1:0]    LED_LATCH;
  logic [3:0]            CAB_FLAGS;
  logic [1:0]            HCOUNT;
  logic [0:0]            LINE;
  logic [15:0]           FRAME;
  logic [NUM_LED*LED_W+3:0] CAB_SNAP;
  logic                  BUSY;
  logic                  OVERFLOW;
  logic [15:0]           DROP_CNT;

  video_stream_logger_if #(.DATA_W(WORD_W)) out_bus ();

  video_stream_logger #(
    .PIX_W      (PIX_W),
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NUM_LED    (NUM_LED),
    .LED_W      (LED_W)
  ) dut (
    .CLK_6MB    (CLK_6MB),
    .nRESET     (nRESET),
    .PIX_EN     (PIX_EN),
    .PIX_DATA   (PIX_DATA),
    .nBNKB      (nBNKB),
    .CAP_START  (CAP_START),
    .CAP_FRAMES (CAP_FRAMES),
    .LED_DATA   (LED_DATA),
    .LED_LATCH  (LED_LATCH),
    .CAB_FLAGS  (CAB_FLAGS),
    .out_if     (out_bus),
    .HCOUNT     (HCOUNT),
    .LINE       (LINE),
    .FRAME      (FRAME),
    .CAB_SNAP   (CAB_SNAP),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW),
    .DROP_CNT   (DROP_CNT)
  );

  int total_checks = 0;
  int bad_checks   = 0;
  int pop_count    = 0;
  int pop_base;

  logic [WORD_W-1:0] exp_q [$];

  // Reference model state
  int        m_h;
  int        m_l;
  logic [15:0] m_f;
  int        m_state;
  logic [7:0] m_remain;

  initial CLK_6MB = 1'b0;
  always #5 CLK_6MB = ~CLK_6MB;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model for the coming edge,
  // then wait for that edge and settle 1 time unit past it.
  task automatic applyStimulus(input logic pix_en, input logic [PIX_W-1:0] data,
                               input logic bnk, input logic start);
    logic [WORD_W-1:0] word;
    bit push;
    bit pop;
    bit fend;
    PIX_EN    = pix_en;
    PIX_DATA  = data;
    nBNKB     = bnk;
    CAP_START = start;
    fend = (m_h == H_TOTAL - 1) && (m_l == V_TOTAL - 1);
    if (m_h < H_TOTAL - 1) word = {2'b00, (bnk ? data : {PIX_W{1'b0}})};
    else if (!fend)        word = {2'b01, {PIX_W{1'b0}}};
    else                   word = {2'b10, PIX_W'(m_f)};
    pop  = (exp_q.size() > 0) && (out_bus.OUT_READY == 1'b1);
    push = 1'b0;
    case (m_state)
      M_IDLE: if (start) begin
        m_state  = M_WAIT;
        m_remain = CAP_FRAMES;
      end
      M_WAIT: if (pix_en && m_h == 0 && m_l == 0) begin
        push    = 1'b1;
        m_state = M_CAP;
      end
      M_CAP: if (pix_en) begin
        push = 1'b1;
        if (fend && m_remain != 0) begin
          m_remain = m_remain - 8'd1;
          if (m_remain == 0) m_state = M_DRAIN;
        end
      end
      default: if (exp_q.size() == 0) m_state = M_IDLE;
    endcase
    if (push && (exp_q.size() < FIFO_DEPTH || pop)) exp_q.push_back(word);
    if (pix_en) begin
      m_h++;
      if (m_h == H_TOTAL) begin
        m_h = 0;
        m_l++;
        if (m_l == V_TOTAL) begin
          m_l = 0;
          m_f = m_f + 16'd1;
        end
      end
    end
    @(posedge CLK_6MB);
    #1;
  endtask

  task automatic resetModel();
    m_h      = 0;
    m_l      = 0;
    m_f      = '0;
    m_state  = M_IDLE;
    m_remain = '0;
    exp_q.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"},    32'(out_bus.OUT_VALID), 0);
    checkOutput({tag, "_data"},     32'(out_bus.OUT_DATA), 0);
    checkOutput({tag, "_hcount"},   32'(HCOUNT), 0);
    checkOutput({tag, "_line"},     32'(LINE), 0);
    checkOutput({tag, "_frame"},    32'(FRAME), 0);
    checkOutput({tag, "_cab_snap"}, 32'(CAB_SNAP), 0);
    checkOutput({tag, "_busy"},     32'(BUSY), 0);
    checkOutput({tag, "_overflow"}, 32'(OVERFLOW), 0);
    checkOutput({tag, "_drop_cnt"}, 32'(DROP_CNT), 0);
  endtask

  // Keep PIX_EN high until the model reaches DRAIN; pixel 1 of line 0 of the
  // captured frame is blanked with a nonzero pixel value.
  task automatic captureFrame();
    for (int i = 0; i < 40 && m_state != M_DRAIN; i++) begin
      if (m_state == M_CAP && m_h == 1 && m_l == 0)
        applyStimulus(1'b1, 21'h1ABCD, 1'b0, 1'b0);
      else
        applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 50 && BUSY !== 1'b0; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    checkOutput({tag, "_busy_fall"}, 32'(BUSY), 0);
    checkOutput({tag, "_queue_left"}, 32'(exp_q.size()), 0);
  endtask

  // Sink monitor: every accepted handshake must match the next expected word.
  always @(negedge CLK_6MB) begin
    if (nRESET && out_bus.OUT_VALID && out_bus.OUT_READY) begin
      pop_count++;
      if (exp_q.size() == 0)
        checkOutput("sink_extra_word", 32'(exp_q.size()), 1);
      else
        checkOutput("sink_word", 32'(out_bus.OUT_DATA), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    nRESET            = 1'b1;
    PIX_EN            = 1'b0;
    PIX_DATA          = '0;
    nBNKB             = 1'b1;
    CAP_START         = 1'b0;
    CAP_FRAMES        = 8'd0;
    LED_DATA          = '0;
    LED_LATCH         = '0;
    CAB_FLAGS         = 4'b1010;
    out_bus.OUT_READY = 1'b0;
    resetModel();

    #2 nRESET = 1'b0;
    @(posedge CLK_6MB);
    @(posedge CLK_6MB);
    #1;
    checkAllZero("reset");
    nRESET = 1'b1;

    // LED channel 1 latches 0xA5, channel 0 latches 0x3C on strobe falls
    LED_DATA  = 8'hA5;
    LED_LATCH = 2'b10;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    LED_LATCH = 2'b00;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    LED_DATA  = 8'h3C;
    LED_LATCH = 2'b01;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    LED_LATCH = 2'b00;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    LED_DATA  = 8'hFF;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("cab_snap_before_frame_end", 32'(CAB_SNAP), 0);

    // Single frame armed mid-frame, sink always ready
    out_bus.OUT_READY = 1'b1;
    CAP_FRAMES        = 8'd1;
    applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    checkOutput("hcount_advance", 32'(HCOUNT), 2);
    checkOutput("line_hold", 32'(LINE), 0);
    applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b1);
    checkOutput("busy_rise", 32'(BUSY), 1);
    checkOutput("no_push_before_sof", 32'(out_bus.OUT_VALID), 0);
    pop_base = pop_count;
    captureFrame();
    waitIdle("single");
    checkOutput("single_word_count", 32'(pop_count - pop_base), 8);
    checkOutput("frame_after_single", 32'(FRAME), 2);
    checkOutput("cab_snap_leds", 32'(CAB_SNAP), 32'hAA53C);

    // Overflow: sink stalled, 7 pushes into a 4-deep FIFO
    out_bus.OUT_READY = 1'b0;
    CAP_FRAMES        = 8'd1;
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    end
    checkOutput("ovf_valid", 32'(out_bus.OUT_VALID), 1);
    checkOutput("ovf_flag", 32'(OVERFLOW), 1);
    checkOutput("ovf_drop_cnt", 32'(DROP_CNT), 3);

    // Full FIFO, frame-end push with a simultaneous pop: no drop, still 4 held
    out_bus.OUT_READY = 1'b1;
    applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    checkOutput("full_pop_drop_cnt", 32'(DROP_CNT), 3);
    pop_base = pop_count;
    waitIdle("overflow");
    checkOutput("full_pop_occupancy", 32'(pop_count - pop_base), 4);
    checkOutput("ovf_sticky_idle", 32'(OVERFLOW), 1);

    // Reset in the middle of a continuous capture with 3 words queued
    out_bus.OUT_READY = 1'b0;
    CAP_FRAMES        = 8'd0;
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("arm_clears_overflow", 32'(OVERFLOW), 0);
    checkOutput("arm_clears_drop_cnt", 32'(DROP_CNT), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, PIX_W'($urandom), 1'b1, 1'b0);
    end
    checkOutput("midcap_valid", 32'(out_bus.OUT_VALID), 1);
    checkOutput("midcap_busy", 32'(BUSY), 1);
    nRESET = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    @(posedge CLK_6MB);
    @(posedge CLK_6MB);
    #1;
    nRESET = 1'b1;

    // Capture after reset works again; LEDs were cleared by reset
    out_bus.OUT_READY = 1'b1;
    CAP_FRAMES        = 8'd1;
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("rearm_busy", 32'(BUSY), 1);
    pop_base = pop_count;
    captureFrame();
    waitIdle("after_reset");
    checkOutput("after_reset_word_count", 32'(pop_count - pop_base), 8);
    checkOutput("cab_snap_leds_cleared", 32'(CAB_SNAP), 32'hA0000);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
